frame_bit_rx: RTL and testbench
===============================

Name: frame_bit_rx

Overview:
Receive side of the enable-framed serial link. The transmitter holds `en` high for the whole frame, and each bit lasts BIT_CYCLES clocks. This block detects frame start on the rising edge of `en_in`, samples `din` at a fixed mid-bit point, and assembles FRAME_BITS bits LSB-first. It presents the parallel word with a one-cycle valid pulse and flags malformed frames (short or overlong `en`).

Parameters:
- BIT_CYCLES, 10: clocks per bit. Must be ≥ 2.
- FRAME_BITS, 2: bits per frame. Must be ≥ 1.
- SAMPLE_IDX, 4: cycle index within a bit (0-based) at which `din` is sampled. Must satisfy 1 ≤ SAMPLE_IDX ≤ BIT_CYCLES-1.

Ports:
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- en_in  in  1  frame enable from the transmitter; high for the full frame.
- din  in  1  serial data, LSB first.
- dout  out  FRAME_BITS  last good frame; held until the next good frame.
- dout_valid  out  1  one-cycle pulse when `dout` updates.
- frame_err  out  1  one-cycle pulse on a malformed frame.
- busy  out  1  high whenever state ≠ IDLE.

Behaviour:
- Clocking and reset: single clock domain; reset is asynchronous and active-low.
- Reset values: state=IDLE; cyc_cnt=0; bit_cnt=0; shift register=0; dout=0; dout_valid=0; frame_err=0.
- en_d (registered `en_in`) resets to 1. As a result, `en_in` already high at reset release does not start a frame; a low-then-high edge is required.
- Counters: cyc_cnt is $clog2(BIT_CYCLES) wide; bit_cnt is $clog2(FRAME_BITS) wide (minimum 1 bit).
- Edge numbering: edge k=0 is the first rising clk edge where en_in=1 and en_d=0.
- IDLE:
  - On start condition (en_in & ~en_d) → RECV, cyc_cnt←1, bit_cnt←0, shift register←0.
  - Otherwise stay in IDLE.
- RECV, evaluated each edge in this priority:
  1. en_in=0 → frame_err=1 for one cycle; dout and dout_valid unchanged (no valid); → IDLE. A new rising edge may start a frame on the very next edge.
  2. cyc_cnt==SAMPLE_IDX → shift[bit_cnt]←din.
  3. cyc_cnt==BIT_CYCLES-1 → cyc_cnt←0.
     - If bit_cnt==FRAME_BITS-1: dout←assembled word (including a sample taken this same edge), dout_valid=1 for one cycle, → GAP.
     - Otherwise bit_cnt←bit_cnt+1.
  4. Otherwise cyc_cnt←cyc_cnt+1.
- Sample timing: bit b is sampled at edge b*BIT_CYCLES+SAMPLE_IDX. `din` at all other edges is ignored.
- Latency: dout/dout_valid are visible after edge FRAME_BITS*BIT_CYCLES-1. With defaults, samples are taken at edges 4 and 14, and valid follows edge 19.
- GAP:
  - en_in=0 → IDLE. The next frame may begin on the following edge, so a 1-cycle gap is legal.
  - en_in=1 on the first GAP edge → frame_err=1 for one cycle (overlong frame). Stay in GAP until en_in=0, with no further error pulses.
- busy: high in RECV and GAP, low in IDLE.
- Simultaneous events:
  - Error and completion cannot coincide; en_in=0 in RECV always wins, so the last-edge word is discarded if en_in is low at that edge.
  - dout_valid and frame_err are never high in the same cycle.
- Reset mid-frame: all outputs drop to reset values immediately. A partial word is discarded, and no valid or error is generated for it.

Test Plan:
1. Basic frame (defaults): en_in high 20 cycles; din=1 for cycles 0–9 and 0 for cycles 10–19 → dout=2'b01, dout_valid pulse one cycle after edge 19; busy high from edge 0 to edge 20.
2. Back-to-back frames: frames 2'b10 and 2'b11 separated by one low cycle → two dout_valid pulses exactly 21 cycles apart, dout=2'b10 then 2'b11, frame_err never asserted.
3. Short frame: after a good frame 2'b01, en_in drops after 12 high cycles → frame_err one-cycle pulse following edge 12, no dout_valid, dout stays 2'b01, busy low next cycle.
4. Overlong frame: en_in held high 25 cycles → dout_valid after edge 19, frame_err after edge 20 only, busy stays high until en_in falls, no new frame until a fresh rising edge.
5. Sample-point isolation: din toggles every cycle except held 1 at edges 4 and 14 → dout=2'b11.
6. Reset mid-frame: rst_n low at cycle 8 of a frame with en_in still high → outputs 0 and busy 0 immediately; after release with en_in high, no frame start; a later low→high edge receives normally.

Source files
------------

// File: rtl/frame_bit_rx.sv
// Receiver for the enable-framed serial link: starts on a rising en_in edge,
// samples din once per bit at SAMPLE_IDX, assembles LSB-first words, flags bad framing.
`timescale 1ns/1ps
module frame_bit_rx #(
  parameter int BIT_CYCLES = 10,
  parameter int FRAME_BITS = 2,
  parameter int SAMPLE_IDX = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_in,
  input  logic                  din,
  output logic [FRAME_BITS-1:0] dout,
  output logic                  dout_valid,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int BW = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam logic [CW-1:0] SMP_IDX  = CW'(SAMPLE_IDX);
  localparam logic [CW-1:0] LAST_CYC = CW'(BIT_CYCLES - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

  typedef enum logic [1:0] {IDLE, RECV, GAP} state_t;

  state_t                  r_state, w_state_n;
  logic [CW-1:0]           r_cyc_cnt, w_cyc_n;
  logic [BW-1:0]           r_bit_cnt, w_bit_n;
  logic [FRAME_BITS-1:0]   r_shift, w_shift_n, w_shift_smp;
  logic [FRAME_BITS-1:0]   r_dout, w_dout_n;
  logic                    r_dout_valid, w_vld_n;
  logic                    r_frame_err, w_err_n;
  logic                    r_en_d;
  logic                    r_gap_first, w_gap_first_n;
  logic                    w_start;

  // en_d resets high so an enable already asserted at reset release is not an edge
  assign w_start = en_in & ~r_en_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_cyc_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_frame_err  <= 1'b0;
      r_en_d       <= 1'b1;
      r_gap_first  <= 1'b0;
    end else begin
      r_state      <= w_state_n;
      r_cyc_cnt    <= w_cyc_n;
      r_bit_cnt    <= w_bit_n;
      r_shift      <= w_shift_n;
      r_dout       <= w_dout_n;
      r_dout_valid <= w_vld_n;
      r_frame_err  <= w_err_n;
      r_en_d       <= en_in;
      r_gap_first  <= w_gap_first_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_cyc_n       = r_cyc_cnt;
    w_bit_n       = r_bit_cnt;
    w_shift_n     = r_shift;
    w_dout_n      = r_dout;
    w_vld_n       = 1'b0;
    w_err_n       = 1'b0;
    w_gap_first_n = r_gap_first;
    // word including a sample taken on this same edge
    w_shift_smp   = r_shift;
    if (r_cyc_cnt == SMP_IDX) w_shift_smp[r_bit_cnt] = din;

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_n = RECV;
          w_cyc_n   = CW'(1);
          w_bit_n   = '0;
          w_shift_n = '0;
        end
      end
      RECV: begin
        if (!en_in) begin
          w_err_n   = 1'b1;
          w_state_n = IDLE;
        end else begin
          w_shift_n = w_shift_smp;
          if (r_cyc_cnt == LAST_CYC) begin
            w_cyc_n = '0;
            if (r_bit_cnt == LAST_BIT) begin
              w_dout_n      = w_shift_smp;
              w_vld_n       = 1'b1;
              w_state_n     = GAP;
              w_gap_first_n = 1'b1;
            end else begin
              w_bit_n = r_bit_cnt + 1'b1;
            end
          end else begin
            w_cyc_n = r_cyc_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        w_gap_first_n = 1'b0;
        if (!en_in)           w_state_n = IDLE;
        else if (r_gap_first) w_err_n   = 1'b1;
      end
      default: w_state_n = IDLE;
    endcase
  end

  assign dout       = r_dout;
  assign dout_valid = r_dout_valid;
  assign frame_err  = r_frame_err;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_frame_bit_rx.sv
// Directed bench for frame_bit_rx with default parameters (10 clocks/bit, 2 bits, sample at 4).
`timescale 1ns/1ps
module tb_frame_bit_rx;
  localparam int BC = 10;
  localparam int FB = 2;
  localparam int SI = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en_in;
  logic          din;
  logic [FB-1:0] dout;
  logic          dout_valid;
  logic          frame_err;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic [63:0] busy_hist;

  frame_bit_rx #(.BIT_CYCLES(BC), .FRAME_BITS(FB), .SAMPLE_IDX(SI)) dut (
    .clk(clk), .rst_n(rst_n), .en_in(en_in), .din(din),
    .dout(dout), .dout_valid(dout_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Drives one frame: edge k = 0 is the first tick with en_in high.
  // Records relative edge of valid/error pulses, the captured word and busy per edge.
  task automatic run_frame(input int nhigh, input int nlow, input logic [FB-1:0] w,
                           input bit tog, output int c0, output int nv, output int vrel,
                           output logic [FB-1:0] vword, output int ne, output int erel,
                           output int nboth);
    nv = 0; ne = 0; nboth = 0; vrel = -1; erel = -1; vword = '0;
    c0 = cyc + 1;
    busy_hist = '0;
    for (int k = 0; k < nhigh + nlow; k++) begin
      en_in = (k < nhigh);
      if (tog) din = ((k % BC) == SI) ? 1'b1 : k[0];
      else     din = (k < nhigh) ? w[(k / BC) % FB] : 1'b0;
      tick();
      if (dout_valid) begin nv++; vrel = k; vword = dout; end
      if (frame_err)  begin ne++; erel = k; end
      if (dout_valid && frame_err) nboth++;
      if (k < 64) busy_hist[k] = busy;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en_in = 1'b0; din = 1'b0;
    #3;
    checks++;
    if ({dout, dout_valid, frame_err, busy} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000", {dout, dout_valid, frame_err, busy});
    end
    tick(); tick();
    rst_n = 1'b1;
    tick(); tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int c0, nv, vr, ne, er, nb; logic [FB-1:0] vw;
    run_frame(20, 2, 2'b01, 1'b0, c0, nv, vr, vw, ne, er, nb);
    checks++;
    if (nv !== 1 || vr !== 19) begin
      failures++; $display("FAIL basic_valid got n=%0d edge=%0d exp n=1 edge=19", nv, vr);
    end
    checks++;
    if (vw !== 2'b01 || dout !== 2'b01) begin
      failures++; $display("FAIL basic_dout got=%b/%b exp=01", vw, dout);
    end
    checks++;
    if (ne !== 0) begin failures++; $display("FAIL basic_err got=%0d exp=0", ne); end
    checks++;
    if (busy_hist[0] !== 1'b1 || busy_hist[19] !== 1'b1 || busy_hist[20] !== 1'b0) begin
      failures++;
      $display("FAIL basic_busy got e0=%b e19=%b e20=%b exp 1 1 0",
               busy_hist[0], busy_hist[19], busy_hist[20]);
    end
  endtask

  task automatic test_back_to_back();
    int c0a, c0b, nva, nvb, va, vb, nea, neb, ea, eb, nb; logic [FB-1:0] wa, wb;
    run_frame(20, 1, 2'b10, 1'b0, c0a, nva, va, wa, nea, ea, nb);
    run_frame(20, 2, 2'b11, 1'b0, c0b, nvb, vb, wb, neb, eb, nb);
    checks++;
    if (nva !== 1 || nvb !== 1 || (c0b + vb) - (c0a + va) !== 21) begin
      failures++;
      $display("FAIL b2b_spacing got n=%0d/%0d gap=%0d exp 1/1 gap=21",
               nva, nvb, (c0b + vb) - (c0a + va));
    end
    checks++;
    if (wa !== 2'b10 || wb !== 2'b11) begin
      failures++; $display("FAIL b2b_words got=%b,%b exp=10,11", wa, wb);
    end
    checks++;
    if (nea + neb !== 0) begin failures++; $display("FAIL b2b_err got=%0d exp=0", nea + neb); end
  endtask

  task automatic test_short_frame();
    int c0, nv, vr, ne, er, nb; logic [FB-1:0] vw;
    run_frame(20, 1, 2'b01, 1'b0, c0, nv, vr, vw, ne, er, nb);
    run_frame(12, 2, 2'b10, 1'b0, c0, nv, vr, vw, ne, er, nb);
    checks++;
    if (ne !== 1 || er !== 12) begin
      failures++; $display("FAIL short_err got n=%0d edge=%0d exp n=1 edge=12", ne, er);
    end
    checks++;
    if (nv !== 0 || dout !== 2'b01) begin
      failures++; $display("FAIL short_dout got nv=%0d dout=%b exp nv=0 dout=01", nv, dout);
    end
    checks++;
    if (busy_hist[11] !== 1'b1 || busy_hist[12] !== 1'b0) begin
      failures++; $display("FAIL short_busy got e11=%b e12=%b exp 1 0", busy_hist[11], busy_hist[12]);
    end
  endtask

  task automatic test_overlong();
    int c0, nv, vr, ne, er, nb; logic [FB-1:0] vw;
    run_frame(25, 3, 2'b10, 1'b0, c0, nv, vr, vw, ne, er, nb);
    checks++;
    if (nv !== 1 || vr !== 19 || vw !== 2'b10) begin
      failures++; $display("FAIL long_valid got n=%0d edge=%0d w=%b exp 1 19 10", nv, vr, vw);
    end
    checks++;
    if (ne !== 1 || er !== 20 || nb !== 0) begin
      failures++; $display("FAIL long_err got n=%0d edge=%0d both=%0d exp 1 20 0", ne, er, nb);
    end
    checks++;
    if (busy_hist[24] !== 1'b1 || busy_hist[25] !== 1'b0 || busy_hist[27] !== 1'b0) begin
      failures++;
      $display("FAIL long_busy got e24=%b e25=%b e27=%b exp 1 0 0",
               busy_hist[24], busy_hist[25], busy_hist[27]);
    end
  endtask

  task automatic test_sample_point();
    int c0, nv, vr, ne, er, nb; logic [FB-1:0] vw;
    run_frame(20, 2, 2'b00, 1'b1, c0, nv, vr, vw, ne, er, nb);
    checks++;
    if (nv !== 1 || vw !== 2'b11) begin
      failures++; $display("FAIL sample_word got n=%0d w=%b exp n=1 w=11", nv, vw);
    end
  endtask

  task automatic test_reset_midframe();
    int c0, nv, vr, ne, er, nb, seen; logic [FB-1:0] vw;
    en_in = 1'b1; din = 1'b1;
    for (int k = 0; k < 8; k++) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dout, dout_valid, frame_err, busy} !== 5'b0) begin
      failures++; $display("FAIL midrst_outputs got=%b exp=00000", {dout, dout_valid, frame_err, busy});
    end
    tick(); tick();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (busy || dout_valid || frame_err) seen++;
    end
    checks++;
    if (seen !== 0) begin failures++; $display("FAIL midrst_nostart got=%0d exp=0", seen); end
    en_in = 1'b0;
    tick();
    run_frame(20, 2, 2'b10, 1'b0, c0, nv, vr, vw, ne, er, nb);
    checks++;
    if (nv !== 1 || vr !== 19 || vw !== 2'b10 || ne !== 0) begin
      failures++;
      $display("FAIL midrst_recover got n=%0d edge=%0d w=%b err=%0d exp 1 19 10 0", nv, vr, vw, ne);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_short_frame();
    test_overlong();
    test_sample_point();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout reached exp finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
